// File: rtl/neuron_grid_pkg.sv
// Shared constants and scheduler state encoding for the neuron grid core.
package neuron_grid_pkg;

  localparam int DEF_NUM_AXONS = 256;
  localparam int DEF_AXON_W    = 8;
  localparam int DEF_NUM_SLOTS = 16;
  localparam int DEF_SLOT_W    = 4;

  typedef enum logic {
    SCHED_IDLE   = 1'b0,
    SCHED_ACTIVE = 1'b1
  } sched_state_t;

endpackage

// File: rtl/scheduler_slot_mem.sv
// Circular array of per-tick spike rows: bit-set port, row-clear port,
// asynchronous row read.
module scheduler_slot_mem
  import neuron_grid_pkg::*;
#(
  parameter int NUM_AXONS = DEF_NUM_AXONS,
  parameter int AXON_W    = DEF_AXON_W,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SLOT_W    = DEF_SLOT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_en,
  input  logic [SLOT_W-1:0]    set_slot,
  input  logic [AXON_W-1:0]    set_axon,
  input  logic                 clr_en,
  input  logic [SLOT_W-1:0]    clr_slot,
  input  logic [SLOT_W-1:0]    rd_slot,
  output logic [NUM_AXONS-1:0] rd_row
);

  logic [NUM_AXONS-1:0] rows [NUM_SLOTS];

  // NOTE: this array is reset on purpose; pending spikes must be lost on reset,
  // so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) rows[i] <= '0;
    end else begin
      if (clr_en) rows[clr_slot] <= '0;
      if (set_en) rows[set_slot][set_axon] <= 1'b1;
    end
  end

  assign rd_row = rows[rd_slot];

endmodule

// File: rtl/axon_spike_scheduler.sv
// Per-core axon spike scheduler: buffers delayed spike packets per tick slot and
// exposes a snapshot of the current slot to the grid controller.
module axon_spike_scheduler
  import neuron_grid_pkg::*;
#(
  parameter int NUM_AXONS = DEF_NUM_AXONS,
  parameter int AXON_W    = DEF_AXON_W,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SLOT_W    = DEF_SLOT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [AXON_W-1:0] pkt_axon,
  input  logic [SLOT_W-1:0] pkt_delay,
  input  logic              scheduler_set,
  input  logic              scheduler_clr,
  input  logic [AXON_W-1:0] axon_num,
  output logic              axon_spike,
  output logic              busy,
  output logic              drop_err,
  output logic              protocol_err
);

  sched_state_t         state, state_next;
  logic [SLOT_W-1:0]    cur_ptr, ptr_next, wr_slot;
  logic [NUM_AXONS-1:0] snap, slot_row;
  logic                 set_ok, clr_ok, tick_ok, misuse;
  logic                 pkt_fire, wr_en, pkt_drop;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_next = state;
    set_ok     = 1'b0;
    clr_ok     = 1'b0;
    tick_ok    = 1'b0;
    misuse     = 1'b0;
    case (state)
      SCHED_IDLE: begin
        tick_ok = tick;
        misuse  = scheduler_clr;
        if (scheduler_set && !scheduler_clr) begin
          set_ok     = 1'b1;
          state_next = SCHED_ACTIVE;
        end
      end
      SCHED_ACTIVE: begin
        misuse = tick | scheduler_set;
        if (scheduler_clr && !scheduler_set) begin
          clr_ok     = 1'b1;
          state_next = SCHED_IDLE;
        end
      end
      default: state_next = SCHED_IDLE;
    endcase
  end

  // Writes aim past the post-tick pointer, so with delay >= 1 they never hit the
  // row being snapshotted or cleared.
  assign ptr_next = tick_ok ? cur_ptr + SLOT_W'(1) : cur_ptr;
  assign pkt_fire = pkt_valid & pkt_ready;
  assign pkt_drop = pkt_fire & (pkt_delay == '0);
  assign wr_en    = pkt_fire & (pkt_delay != '0);
  assign wr_slot  = ptr_next + pkt_delay;

  scheduler_slot_mem #(
    .NUM_AXONS (NUM_AXONS),
    .AXON_W    (AXON_W),
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_slot_mem (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (wr_en),
    .set_slot (wr_slot),
    .set_axon (pkt_axon),
    .clr_en   (clr_ok),
    .clr_slot (cur_ptr),
    .rd_slot  (cur_ptr),
    .rd_row   (slot_row)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SCHED_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_ptr      <= '0;
      snap         <= '0;
      pkt_ready    <= 1'b0;
      drop_err     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      cur_ptr   <= ptr_next;
      pkt_ready <= 1'b1;
      if (set_ok)      snap <= slot_row;
      else if (clr_ok) snap <= '0;
      if (pkt_drop) drop_err     <= 1'b1;
      if (misuse)   protocol_err <= 1'b1;
    end
  end

  assign axon_spike = snap[axon_num];
  assign busy       = (state == SCHED_ACTIVE);

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Self-checking bench for axon_spike_scheduler against a spike-list model keyed
// by absolute delivery tick.
module tb_axon_spike_scheduler;

  localparam int NA = 256;
  localparam int NS = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tick = 1'b0, pkt_valid = 1'b0, scheduler_set = 1'b0, scheduler_clr = 1'b0;
  logic [7:0] pkt_axon = '0, axon_num = '0;
  logic [3:0] pkt_delay = '0;
  logic       pkt_ready, axon_spike, busy, drop_err, protocol_err;

  axon_spike_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick          (tick),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_axon      (pkt_axon),
    .pkt_delay     (pkt_delay),
    .scheduler_set (scheduler_set),
    .scheduler_clr (scheduler_clr),
    .axon_num      (axon_num),
    .axon_spike    (axon_spike),
    .busy          (busy),
    .drop_err      (drop_err),
    .protocol_err  (protocol_err)
  );

  always #500 clk = ~clk;

  // Reference model: list of pending spikes with absolute due tick.
  typedef struct { int axon; int due; } spike_t;
  spike_t         pend[$];
  int             tick_cnt;
  bit             act_m, rdy_m, drop_m, perr_m;
  logic [NA-1:0]  snap_m;
  int             n_cmp = 0, n_bad = 0;
  logic [NA-1:0]  got, want;

  function automatic logic [NA-1:0] due_bits(int slot);
    logic [NA-1:0] b = '0;
    foreach (pend[i]) if (pend[i].due % NS == slot) b[pend[i].axon] = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    pend.delete();
    tick_cnt = 0; act_m = 0; rdy_m = 0; drop_m = 0; perr_m = 0; snap_m = '0;
  endtask

  // One clock: drive while clk is low, update the model at the edge, return at negedge.
  task automatic cyc(input bit t, input bit pv, input int ax, input int d,
                     input bit s, input bit c);
    bit     t_ok;
    int     slot_now;
    spike_t keep[$];
    spike_t e;
    tick = t; pkt_valid = pv; pkt_axon = 8'(ax); pkt_delay = 4'(d);
    scheduler_set = s; scheduler_clr = c;
    @(posedge clk);
    t_ok = t && !act_m;
    slot_now = tick_cnt % NS;
    if (t && act_m) perr_m = 1;
    if (s && c) perr_m = 1;
    else if (s) begin
      if (act_m) perr_m = 1;
      else begin act_m = 1; snap_m = due_bits(slot_now); end
    end else if (c) begin
      if (!act_m) perr_m = 1;
      else begin
        act_m = 0; snap_m = '0;
        foreach (pend[i]) if (pend[i].due % NS != slot_now) keep.push_back(pend[i]);
        pend = keep;
      end
    end
    if (pv && rdy_m) begin
      if (d == 0) drop_m = 1;
      else begin e.axon = ax; e.due = tick_cnt + int'(t_ok) + d; pend.push_back(e); end
    end
    if (t_ok) tick_cnt++;
    rdy_m = 1;
    @(negedge clk);
    tick = 0; pkt_valid = 0; scheduler_set = 0; scheduler_clr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 1, 0, 0);
  endtask

  // Sweeps axon_num across the whole snapshot while clk is low.
  task automatic read_all(output logic [NA-1:0] v);
    for (int i = 0; i < NA; i++) begin
      axon_num = 8'(i);
      #1 v[i] = axon_spike;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #5;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #10;
    do_reset();
    n_cmp++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", pkt_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if ({drop_err, protocol_err} !== 2'b00) begin n_bad++; $display("FAIL reset_errs got=%b exp=00", {drop_err, protocol_err}); end
    read_all(got);
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL reset_spikes got=%h exp=0", got); end
    release_reset();
    idle(1);
    n_cmp++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got=%b exp=1", pkt_ready); end
  endtask

  task automatic test_basic();
    want = '0; want[5] = 1'b1;
    cyc(0, 1, 5, 2, 0, 0);
    ticks(1);
    cyc(0, 0, 0, 1, 1, 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    read_all(got);
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL basic_early got=%h exp=0", got); end
    cyc(0, 0, 0, 1, 0, 1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
    ticks(1);
    cyc(0, 0, 0, 1, 1, 0);
    read_all(got);
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL basic_axon5 got=%h exp=%h", got, want); end
    cyc(0, 0, 0, 1, 0, 1);
    read_all(got);
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL basic_idle_zero got=%h exp=0", got); end
    ticks(16);
    cyc(0, 0, 0, 1, 1, 0);
    read_all(got);
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL basic_revisit got=%h exp=0", got); end
    cyc(0, 0, 0, 1, 0, 1);
  endtask

  task automatic test_same_cycle_tick();
    cyc(1, 1, 7, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    read_all(got);
    n_cmp++; if (got[7] !== 1'b0 || got !== snap_m) begin n_bad++; $display("FAIL same_tick_early got=%h exp=%h", got, snap_m); end
    cyc(0, 0, 0, 1, 0, 1);
    ticks(1);
    cyc(0, 0, 0, 1, 1, 0);
    read_all(got);
    n_cmp++; if (got[7] !== 1'b1 || got !== snap_m) begin n_bad++; $display("FAIL same_tick_late got=%h exp=%h", got, snap_m); end
    cyc(0, 0, 0, 1, 0, 1);
  endtask

  task automatic test_drop();
    n_cmp++; if (drop_err !== 1'b0) begin n_bad++; $display("FAIL drop_pre got=%b exp=0", drop_err); end
    cyc(0, 1, 11, 0, 0, 0);
    n_cmp++; if (drop_err !== 1'b1) begin n_bad++; $display("FAIL drop_flag got=%b exp=1", drop_err); end
    for (int k = 0; k < NS; k++) begin
      ticks(1);
      cyc(0, 0, 0, 1, 1, 0);
      read_all(got);
      n_cmp++; if (got[11] !== 1'b0) begin n_bad++; $display("FAIL drop_stored slot=%0d got=%b exp=0", k, got[11]); end
      cyc(0, 0, 0, 1, 0, 1);
    end
    n_cmp++; if (drop_err !== 1'b1) begin n_bad++; $display("FAIL drop_sticky got=%b exp=1", drop_err); end
  endtask

  task automatic test_wrap();
    do_reset();
    release_reset();
    ticks(15);
    cyc(0, 1, 3, 3, 0, 0);
    want = '0; want[3] = 1'b1;
    ticks(2);
    cyc(0, 0, 0, 1, 1, 0);
    read_all(got);
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL wrap_early got=%h exp=0", got); end
    cyc(0, 0, 0, 1, 0, 1);
    ticks(1);
    cyc(0, 0, 0, 1, 1, 0);
    read_all(got);
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL wrap_slot2 got=%h exp=%h", got, want); end
    cyc(0, 0, 0, 1, 0, 1);
  endtask

  task automatic test_protocol();
    do_reset();
    release_reset();
    idle(1);
    cyc(0, 1, 9, 2, 0, 0);
    ticks(1);
    cyc(0, 0, 0, 1, 1, 0);
    n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL proto_clean got=%b exp=0", protocol_err); end
    cyc(1, 0, 0, 1, 0, 0);
    n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL proto_tick_busy got=%b exp=1", protocol_err); end
    cyc(0, 0, 0, 1, 0, 1);
    ticks(1);
    cyc(0, 0, 0, 1, 1, 0);
    want = '0; want[9] = 1'b1;
    read_all(got);
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL proto_ptr_held got=%h exp=%h", got, want); end
    cyc(0, 0, 0, 1, 0, 1);
    do_reset();
    release_reset();
    cyc(0, 0, 0, 1, 0, 1);
    n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL proto_clr_idle got=%b exp=1", protocol_err); end
    do_reset();
    release_reset();
    cyc(0, 0, 0, 1, 1, 1);
    n_cmp++; if ({busy, protocol_err} !== 2'b01) begin n_bad++; $display("FAIL proto_set_clr got=%b exp=01", {busy, protocol_err}); end
  endtask

  task automatic test_reset_active();
    do_reset();
    release_reset();
    idle(1);
    cyc(0, 1, 20, 1, 0, 0);
    cyc(0, 1, 40, 2, 0, 0);
    ticks(1);
    cyc(0, 0, 0, 1, 1, 0);
    read_all(got);
    n_cmp++; if (got[20] !== 1'b1) begin n_bad++; $display("FAIL rst_act_pre got=%b exp=1", got[20]); end
    do_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_act_busy got=%b exp=0", busy); end
    read_all(got);
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL rst_act_spike got=%h exp=0", got); end
    release_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, 1, 0);
      read_all(got);
      n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL rst_act_read slot=%0d got=%h exp=0", k, got); end
      cyc(0, 0, 0, 1, 0, 1);
      ticks(1);
    end
  endtask

  task automatic test_random();
    bit t, pv, s, c;
    do_reset();
    release_reset();
    for (int i = 0; i < 300; i++) begin
      t  = ($urandom_range(3) == 0);
      pv = $urandom_range(1);
      if (act_m) begin s = ($urandom_range(24) == 0); c = ($urandom_range(2) == 0); end
      else       begin s = ($urandom_range(3) == 0);  c = ($urandom_range(24) == 0); end
      if (act_m && t && $urandom_range(7) != 0) t = 0;
      cyc(t, pv, $urandom_range(NA - 1), $urandom_range(NS - 1), s, c);
      n_cmp++;
      if ({pkt_ready, busy, drop_err, protocol_err} !== {rdy_m, act_m, drop_m, perr_m}) begin
        n_bad++;
        $display("FAIL rand_flags cyc=%0d got=%b exp=%b", i,
                 {pkt_ready, busy, drop_err, protocol_err}, {rdy_m, act_m, drop_m, perr_m});
      end
      read_all(got);
      n_cmp++; if (got !== snap_m) begin n_bad++; $display("FAIL rand_snap cyc=%0d got=%h exp=%h", i, got, snap_m); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_same_cycle_tick();
    test_drop();
    test_wrap();
    test_protocol();
    test_reset_active();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
